// File: rtl/list_sum_datapath.sv
// Linked-list summation datapath: node memory, NEXT pointer, SUM accumulator and node counter.
// Optional overflow detection is built only when LIST_SUM_OVF_EN is defined; otherwise ovf is tied to 0.
module list_sum_datapath #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int SW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LD_SUM,
  input  logic          LD_NEXT,
  input  logic          SUM_SEL,
  input  logic          NEXT_SEL,
  input  logic          A_SEL,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          next_zero,
  output logic [SW-1:0] sum,
  output logic [AW-1:0] node_count,
  output logic          ovf
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_next;
  logic [AW-1:0] r_count;
  logic [SW-1:0] r_sum;

  logic [AW-1:0] w_rd_addr;
  logic [DW-1:0] w_mem_rd;
  logic [SW-1:0] w_sum_nxt;
  logic          w_acc;
  logic          w_clr;

  // Pointer word lives at NEXT+1; the AW-bit add wraps 2^AW-1 back to 0.
  assign w_rd_addr = A_SEL ? r_next : r_next + AW'(1);
  assign w_mem_rd  = r_mem[w_rd_addr];
  assign next_zero = (w_mem_rd[AW-1:0] == '0);

  assign w_acc = LD_SUM & SUM_SEL;
  assign w_clr = LD_SUM & ~SUM_SEL;

`ifdef LIST_SUM_OVF_EN
  logic [SW:0] w_add;
  logic        r_ovf;

  assign w_add     = {1'b0, r_sum} + (SW+1)'(w_mem_rd);
  assign w_sum_nxt = w_add[SW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_clr) begin
      r_ovf <= 1'b0;
    end else if (w_acc && w_add[SW]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_sum_nxt = r_sum + SW'(w_mem_rd);
  assign ovf       = 1'b0;
`endif

  // Memory is not reset so host preloads survive a mid-walk reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_next  <= '0;
      r_count <= '0;
    end else begin
      if (LD_SUM) begin
        r_sum   <= SUM_SEL ? w_sum_nxt : '0;
        r_count <= SUM_SEL ? r_count + AW'(1) : '0;
      end
      if (LD_NEXT) begin
        r_next <= NEXT_SEL ? w_mem_rd[AW-1:0] : '0;
      end
    end
  end

  assign sum        = r_sum;
  assign node_count = r_count;

endmodule

// File: tb/tb_list_sum_datapath.sv
// Directed self-checking bench for list_sum_datapath (SW overridden to 16 to reach overflow).
module tb_list_sum_datapath;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SW = 16;
`ifdef LIST_SUM_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          LD_SUM = 1'b0, LD_NEXT = 1'b0, SUM_SEL = 1'b0, NEXT_SEL = 1'b0, A_SEL = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          next_zero;
  logic [SW-1:0] sum;
  logic [AW-1:0] node_count;
  logic          ovf;

  int total = 0;
  int bad = 0;

  list_sum_datapath #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .LD_SUM(LD_SUM), .LD_NEXT(LD_NEXT), .SUM_SEL(SUM_SEL), .NEXT_SEL(NEXT_SEL), .A_SEL(A_SEL),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .next_zero(next_zero), .sum(sum), .node_count(node_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic ls, input logic ln, input logic ss, input logic ns, input logic as);
    LD_SUM = ls; LD_NEXT = ln; SUM_SEL = ss; NEXT_SEL = ns; A_SEL = as;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    host_wr(8'd0, 16'd5);  host_wr(8'd1, 16'd4);
    host_wr(8'd4, 16'd7);  host_wr(8'd5, 16'd10);
    host_wr(8'd10, 16'd3); host_wr(8'd11, 16'd0);
    ctrl(1, 1, 1, 1, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ctrl(0, 0, 0, 0, 0);
    #1;
    total++; if (sum !== 16'd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", sum); end
    total++; if (node_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", node_count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (dut.r_next !== 8'd0) begin bad++; $display("FAIL reset_next got=%0d exp=0", dut.r_next); end
    // NEXT=0, A_SEL=0 reads mem[1]=4
    total++; if (next_zero !== 1'b0) begin bad++; $display("FAIL reset_next_zero got=%b exp=0", next_zero); end
    total++; if (dut.r_mem[0] !== 16'd5) begin bad++; $display("FAIL reset_mem0 got=%0d exp=5", dut.r_mem[0]); end
  endtask

  task automatic test_walk(input string tag);
    logic [SW-1:0] exp_sum [3];
    logic [AW-1:0] exp_next [3];
    logic          exp_nz [3];
    exp_sum  = '{16'd5, 16'd12, 16'd15};
    exp_next = '{8'd4, 8'd10, 8'd0};
    exp_nz   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      ctrl(1, 0, 1, 1, 1);
      tick();
      total++; if (sum !== exp_sum[i]) begin bad++; $display("FAIL %s_sum%0d got=%0d exp=%0d", tag, i, sum, exp_sum[i]); end
      ctrl(0, 1, 1, 1, 0);
      #1;
      total++; if (next_zero !== exp_nz[i]) begin bad++; $display("FAIL %s_nz%0d got=%b exp=%b", tag, i, next_zero, exp_nz[i]); end
      tick();
      total++; if (dut.r_next !== exp_next[i]) begin bad++; $display("FAIL %s_next%0d got=%0d exp=%0d", tag, i, dut.r_next, exp_next[i]); end
    end
    ctrl(0, 0, 0, 0, 0);
    total++; if (node_count !== 8'd3) begin bad++; $display("FAIL %s_count got=%0d exp=3", tag, node_count); end
  endtask

  task automatic test_hold();
    ctrl(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (sum !== 16'd15 || dut.r_next !== 8'd0) begin
        bad++; $display("FAIL hold%0d sum=%0d next=%0d exp sum=15 next=0", i, sum, dut.r_next);
      end
    end
  endtask

  task automatic clear_regs();
    ctrl(1, 1, 0, 0, 0);
    tick();
    ctrl(0, 0, 0, 0, 0);
  endtask

  task automatic test_clear_restart();
    clear_regs();
    total++; if (sum !== 16'd0) begin bad++; $display("FAIL clear_sum got=%0d exp=0", sum); end
    total++; if (node_count !== 8'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", node_count); end
    test_walk("rewalk");
  endtask

  task automatic test_overflow();
    host_wr(8'd0, 16'hFFFF); host_wr(8'd1, 16'd2);
    host_wr(8'd2, 16'd2);    host_wr(8'd3, 16'd0);
    clear_regs();
    ctrl(1, 0, 1, 1, 1); tick();
    total++; if (sum !== 16'hFFFF || ovf !== 1'b0) begin bad++; $display("FAIL ovf_step1 sum=%h ovf=%b exp sum=ffff ovf=0", sum, ovf); end
    ctrl(0, 1, 1, 1, 0); tick();
    ctrl(1, 0, 1, 1, 1); tick();
    total++; if (sum !== 16'h0001 || ovf !== EXP_OVF) begin bad++; $display("FAIL ovf_step2 sum=%h ovf=%b exp sum=0001 ovf=%b", sum, ovf, EXP_OVF); end
    ctrl(0, 1, 1, 1, 0); #1;
    total++; if (next_zero !== 1'b1) begin bad++; $display("FAIL ovf_end_nz got=%b exp=1", next_zero); end
    tick();
    ctrl(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    total++; if (ovf !== EXP_OVF) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovf, EXP_OVF); end
    clear_regs();
    total++; if (ovf !== 1'b0 || sum !== 16'd0) begin bad++; $display("FAIL ovf_clear ovf=%b sum=%h exp ovf=0 sum=0", ovf, sum); end
  endtask

  task automatic test_wrap_write();
    host_wr(8'd1, 16'h00FF);
    ctrl(0, 1, 0, 1, 0); tick();
    ctrl(0, 0, 0, 0, 0);
    total++; if (dut.r_next !== 8'hFF) begin bad++; $display("FAIL wrap_next got=%h exp=ff", dut.r_next); end
    // NEXT=FF, A_SEL=0 reads address 0 which holds FFFF
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'h0100;
    #1;
    total++; if (next_zero !== 1'b0) begin bad++; $display("FAIL wrap_old_data got=%b exp=0", next_zero); end
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (next_zero !== 1'b1) begin bad++; $display("FAIL wrap_new_data got=%b exp=1", next_zero); end
  endtask

  initial begin
    #2;
    test_reset();
    test_walk("walk");
    test_hold();
    test_clear_restart();
    test_overflow();
    test_wrap_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
